ram_arbiter: RTL

- Two-port arbiter and sequencer that shares one single-port RAM between requesters A and B.
- The RAM has 16-bit words and 8 entries, with a one-cycle registered read. RdEn and WrEn are exclusive, and RdData holds when RdEn is low.
- Accepts one request per arbitration and drives exactly one RAM enable pulse per operation. Returns read data with a one-cycle rvalid to the requester that owns the read.
- Sits between two client blocks and the RAM instance; it is the only driver of the RAM's Address, WrData, WrEn and RdEn.

---
 rtl/ram_arb_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/ram_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared encodings and default widths for the RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    localparam int c_DEF_ADDRESS = 3;
    localparam int c_DEF_WIDTH   = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        READ_WAIT = 2'd2
    } state_t;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester pick logic. Round-robin on ties by default;
//               `RAM_ARB_FIXED_PRIO_EN makes A win every tie.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic ptr,
    output logic sel,
    output logic any
);

    assign any = req_a | req_b;

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Pointer is ignored: B only wins when A is idle.
    logic w_unused_ptr;
    assign w_unused_ptr = ptr;
    assign sel          = (req_a) ? SIDE_A : (req_b ? SIDE_B : SIDE_A);
`else
    assign sel = (req_a & req_b) ? ptr : (req_b ? SIDE_B : SIDE_A);
`endif

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module      : ram_arbiter
// Description : Shares one single-port RAM (1-cycle registered read) between
//               requesters A and B; all outputs registered.
//               Option macro: RAM_ARB_FIXED_PRIO_EN (A always wins ties).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDRESS = c_DEF_ADDRESS,
    parameter int WIDTH   = c_DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_req,
    input  logic               a_we,
    input  logic [ADDRESS-1:0] a_addr,
    input  logic [WIDTH-1:0]   a_wdata,
    output logic               a_gnt,
    output logic               a_rvalid,
    output logic [WIDTH-1:0]   a_rdata,
    input  logic               b_req,
    input  logic               b_we,
    input  logic [ADDRESS-1:0] b_addr,
    input  logic [WIDTH-1:0]   b_wdata,
    output logic               b_gnt,
    output logic               b_rvalid,
    output logic [WIDTH-1:0]   b_rdata,
    output logic [ADDRESS-1:0] ram_Address,
    output logic [WIDTH-1:0]   ram_WrData,
    output logic               ram_WrEn,
    output logic               ram_RdEn,
    input  logic [WIDTH-1:0]   ram_RdData
);

    state_t r_state;
    logic   r_ptr;
    logic   r_owner;
    logic   r_is_read;

    logic   w_sel;
    logic   w_any;
    logic   w_we;

    rr_arb2 u_pick (
        .req_a (a_req),
        .req_b (b_req),
        .ptr   (r_ptr),
        .sel   (w_sel),
        .any   (w_any)
    );

    assign w_we = (w_sel == SIDE_B) ? b_we : a_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= SIDE_A;
            r_owner     <= SIDE_A;
            r_is_read   <= 1'b0;
            a_gnt       <= 1'b0;
            b_gnt       <= 1'b0;
            a_rvalid    <= 1'b0;
            b_rvalid    <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            ram_Address <= '0;
            ram_WrData  <= '0;
            ram_WrEn    <= 1'b0;
            ram_RdEn    <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses; address/data hold their last value.
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            ram_WrEn <= 1'b0;
            ram_RdEn <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_ptr       <= ~w_sel;
                        r_owner     <= w_sel;
                        r_is_read   <= ~w_we;
                        ram_Address <= (w_sel == SIDE_B) ? b_addr : a_addr;
                        ram_WrData  <= (w_sel == SIDE_B) ? b_wdata : a_wdata;
                        ram_WrEn    <= w_we;
                        ram_RdEn    <= ~w_we;
                        a_gnt       <= (w_sel == SIDE_A);
                        b_gnt       <= (w_sel == SIDE_B);
                        r_state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    r_state <= r_is_read ? READ_WAIT : IDLE;
                end

                READ_WAIT: begin
                    if (r_owner == SIDE_B) begin
                        b_rdata  <= ram_RdData;
                        b_rvalid <= 1'b1;
                    end else begin
                        a_rdata  <= ram_RdData;
                        a_rvalid <= 1'b1;
                    end
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
